// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store initiator and a data-memory responder.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data memory answering RV32I loads/stores after a fixed number of wait states.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = 4'((WAIT_STATES == 32'd0) ? 32'd0 : (WAIT_STATES - 32'd1));

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_WAIT = 3'b010,
        ST_RESP = 3'b100
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic          accept_s;
    logic          access_s;
    logic          op_we_s;
    logic [31:0]   op_addr_s;
    logic [31:0]   op_wdata_s;
    logic [2:0]    op_f3_s;
    logic          op_err_s;
    logic [AW-1:0] idx_s;
    logic [3:0]    be_s;
    logic [31:0]   lanes_s;

    function automatic logic req_error(input logic we, input logic [31:0] addr, input logic [2:0] f3);
        logic e;
        case (f3)
            3'b000:  e = 1'b0;
            3'b001:  e = addr[0];
            3'b010:  e = |addr[1:0];
            3'b100:  e = we;
            3'b101:  e = we | addr[0];
            default: e = 1'b1;
        endcase
        return e | (|addr[31:AW+2]);
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << a;
            2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] l;
        case (f3[1:0])
            2'b00:   l = {4{wd[7:0]}};
            2'b01:   l = {2{wd[15:0]}};
            default: l = wd;
        endcase
        return l;
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{a, 3'b000} +: 8];
        h = a[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Operand source: live inputs while idle (zero-wait case), captured copy otherwise.
    always_comb begin
        accept_s   = (state_q == ST_IDLE) && bus.req_valid;
        access_s   = reset && (((WAIT_STATES == 32'd0) && accept_s) ||
                               ((state_q == ST_WAIT) && (cnt_q == 4'd0)));
        op_we_s    = (state_q == ST_IDLE) ? bus.req_we     : we_q;
        op_addr_s  = (state_q == ST_IDLE) ? bus.req_addr   : addr_q;
        op_wdata_s = (state_q == ST_IDLE) ? bus.req_wdata  : wdata_q;
        op_f3_s    = (state_q == ST_IDLE) ? bus.req_funct3 : f3_q;
        op_err_s   = req_error(op_we_s, op_addr_s, op_f3_s);
        idx_s      = op_addr_s[AW+1:2];
        be_s       = byte_en(op_f3_s, op_addr_s[1:0]);
        lanes_s    = store_lanes(op_f3_s, op_wdata_s);
    end

    // Next-state and wait counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_d = (WAIT_STATES == 32'd0) ? ST_RESP : ST_WAIT;
                    cnt_d   = WAIT_INIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Request capture and response data; response is latched on the edge entering RESP.
    always_comb begin
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (accept_s) begin
            we_d    = bus.req_we;
            addr_d  = bus.req_addr;
            wdata_d = bus.req_wdata;
            f3_d    = bus.req_funct3;
        end else begin
            we_d    = we_q;
        end
        if (access_s) begin
            err_d   = op_err_s;
            rdata_d = (op_err_s || op_we_s) ? 32'd0 : load_ext(op_f3_s, op_addr_s[1:0], mem_q[idx_s]);
        end else if ((state_q == ST_RESP) && bus.rsp_ready) begin
            err_d   = 1'b0;
            rdata_d = 32'd0;
        end else begin
            err_d   = err_q;
        end
    end

    // State, captured request and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage array: byte-lane writes, deliberately untouched by reset.
    always_ff @(posedge clk) begin
        if (access_s && op_we_s && !op_err_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem_q[idx_s][8*b +: 8] <= lanes_s[8*b +: 8];
                end
            end
        end
    end

    // Bus outputs decoded from registered state and response flops.
    always_comb begin
        bus.req_ready = (state_q == ST_IDLE);
        bus.rsp_valid = (state_q == ST_RESP);
        bus.rsp_rdata = rdata_q;
        bus.rsp_err   = err_q;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: instance A (256 words, 1 wait state) and instance B (16 words, 3 wait states).
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a_n, rst_b_n;
    logic        sel;
    logic        req_valid, req_we, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        o_req_ready, o_rsp_valid, o_rsp_err;
    logic [31:0] o_rsp_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    dmem_responder_if if_a ();
    dmem_responder_if if_b ();

    assign if_a.req_valid  = req_valid & ~sel;
    assign if_b.req_valid  = req_valid & sel;
    assign if_a.req_we     = req_we;
    assign if_b.req_we     = req_we;
    assign if_a.req_addr   = req_addr;
    assign if_b.req_addr   = req_addr;
    assign if_a.req_wdata  = req_wdata;
    assign if_b.req_wdata  = req_wdata;
    assign if_a.req_funct3 = req_funct3;
    assign if_b.req_funct3 = req_funct3;
    assign if_a.rsp_ready  = rsp_ready & ~sel;
    assign if_b.rsp_ready  = rsp_ready & sel;

    assign o_req_ready = sel ? if_b.req_ready : if_a.req_ready;
    assign o_rsp_valid = sel ? if_b.rsp_valid : if_a.rsp_valid;
    assign o_rsp_rdata = sel ? if_b.rsp_rdata : if_a.rsp_rdata;
    assign o_rsp_err   = sel ? if_b.rsp_err   : if_a.rsp_err;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(1)) dut_a (
        .clk(clk), .reset(rst_a_n), .bus(if_a.slave)
    );

    dmem_responder #(.DEPTH_WORDS(16), .WAIT_STATES(3)) dut_b (
        .clk(clk), .reset(rst_b_n), .bus(if_b.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".req_ready"}, 32'(o_req_ready), 32'd1);
        check({tag, ".rsp_valid"}, 32'(o_rsp_valid), 32'd0);
        check({tag, ".rsp_rdata"}, o_rsp_rdata, 32'd0);
        check({tag, ".rsp_err"},   32'(o_rsp_err), 32'd0);
    endtask

    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] f3, input int exp_lat,
                       input logic [31:0] exp_rdata, input logic exp_err, input int stall);
        int lat;
        @(negedge clk);
        check({tag, ".accept_ready"}, 32'(o_req_ready), 32'd1);
        req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3; req_valid = 1'b1;
        @(posedge clk);
        #1;
        // Scramble inputs after acceptance; the captured request must not follow them.
        req_valid = 1'b0; req_we = ~we; req_addr = 32'h0000_0000;
        req_wdata = 32'hFFFF_FFFF; req_funct3 = 3'b010;
        lat = 1;
        while (!o_rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".rdata"}, o_rsp_rdata, exp_rdata);
        check({tag, ".err"}, 32'(o_rsp_err), 32'(exp_err));
        check({tag, ".busy"}, 32'(o_req_ready), 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check({tag, ".stall_valid"}, 32'(o_rsp_valid), 32'd1);
            check({tag, ".stall_rdata"}, o_rsp_rdata, exp_rdata);
            check({tag, ".stall_ready"}, 32'(o_req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({tag, ".done_valid"}, 32'(o_rsp_valid), 32'd0);
        check({tag, ".done_ready"}, 32'(o_req_ready), 32'd1);
    endtask

    initial begin
        sel = 1'b0; rst_a_n = 1'b0; rst_b_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        req_funct3 = 3'b010; rsp_ready = 1'b0;
        #12;
        check_idle_outputs("reset_a");
        sel = 1'b1;
        check_idle_outputs("reset_b");
        sel = 1'b0;
        @(negedge clk);
        rst_a_n = 1'b1; rst_b_n = 1'b1;

        // Instance A: word, byte, half accesses and error cases.
        txn("sw_10",      1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 2, 32'h0,        1'b0, 0);
        txn("lw_10",      1'b0, 32'h10, 32'h0,        3'b010, 2, 32'hDEADBEEF, 1'b0, 0);
        txn("sb_11",      1'b1, 32'h11, 32'h12345680, 3'b000, 2, 32'h0,        1'b0, 0);
        txn("lb_11",      1'b0, 32'h11, 32'h0,        3'b000, 2, 32'hFFFFFF80, 1'b0, 0);
        txn("lbu_11",     1'b0, 32'h11, 32'h0,        3'b100, 2, 32'h00000080, 1'b0, 0);
        txn("lw_10b",     1'b0, 32'h10, 32'h0,        3'b010, 2, 32'hDEAD80EF, 1'b0, 0);
        txn("lh_13",      1'b0, 32'h13, 32'h0,        3'b001, 2, 32'h0,        1'b1, 0);
        txn("sw_12",      1'b1, 32'h12, 32'h55555555, 3'b010, 2, 32'h0,        1'b1, 0);
        txn("lw_10c",     1'b0, 32'h10, 32'h0,        3'b010, 2, 32'hDEAD80EF, 1'b0, 0);
        txn("lw_range",   1'b0, 32'h400, 32'h0,       3'b010, 2, 32'h0,        1'b1, 0);
        txn("sw_14",      1'b1, 32'h14, 32'h11223344, 3'b010, 2, 32'h0,        1'b0, 0);
        txn("sh_16",      1'b1, 32'h16, 32'hFFFFABCD, 3'b001, 2, 32'h0,        1'b0, 0);
        txn("s_f3_100",   1'b1, 32'h14, 32'hFFFFFFFF, 3'b100, 2, 32'h0,        1'b1, 0);
        txn("s_f3_101",   1'b1, 32'h14, 32'hFFFFFFFF, 3'b101, 2, 32'h0,        1'b1, 0);
        txn("l_f3_011",   1'b0, 32'h14, 32'h0,        3'b011, 2, 32'h0,        1'b1, 0);
        txn("lw_14",      1'b0, 32'h14, 32'h0,        3'b010, 2, 32'hABCD3344, 1'b0, 0);
        txn("lh_16",      1'b0, 32'h16, 32'h0,        3'b001, 2, 32'hFFFFABCD, 1'b0, 0);
        txn("lhu_16",     1'b0, 32'h16, 32'h0,        3'b101, 2, 32'h0000ABCD, 1'b0, 0);
        txn("lb_14",      1'b0, 32'h14, 32'h0,        3'b000, 2, 32'h00000044, 1'b0, 0);
        txn("lb_17",      1'b0, 32'h17, 32'h0,        3'b000, 2, 32'hFFFFFFAB, 1'b0, 0);
        txn("lw_stall",   1'b0, 32'h10, 32'h0,        3'b010, 2, 32'hDEAD80EF, 1'b0, 5);

        // Instance B: longer latency, range limit and reset in WAIT / RESP.
        sel = 1'b1;
        txn("b_sw_8",     1'b1, 32'h8,  32'hCAFEF00D, 3'b010, 4, 32'h0,        1'b0, 0);
        txn("b_lw_range", 1'b0, 32'h40, 32'h0,        3'b010, 4, 32'h0,        1'b1, 0);

        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h8; req_wdata = 32'h0BADBEEF; req_funct3 = 3'b010; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst_b_n = 1'b0;
        #1;
        check_idle_outputs("b_rst_wait");
        @(negedge clk);
        rst_b_n = 1'b1;

        @(negedge clk);
        req_we = 1'b0; req_addr = 32'h8; req_funct3 = 3'b010; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("b_resp_valid", 32'(o_rsp_valid), 32'd1);
        check("b_resp_rdata", o_rsp_rdata, 32'hCAFEF00D);
        @(negedge clk);
        rst_b_n = 1'b0;
        #1;
        check_idle_outputs("b_rst_resp");
        @(negedge clk);
        rst_b_n = 1'b1;

        txn("b_lw_8",     1'b0, 32'h8,  32'h0,        3'b010, 4, 32'hCAFEF00D, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning number of 32-bit words of storage (power of two, 16..4096).
REQ-002 SHALL have parameter WAIT_STATES, default 1, meaning extra cycles between request acceptance and response (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 SHALL have port req_funct3  input  3  RV32I size/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  initiator consumes response.
REQ-013 SHALL have port rsp_rdata  output  32  load data, extended per funct3; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  output  1  request was rejected (misaligned, out of range, illegal code).

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE; a request is accepted on a cycle with req_valid=1 and req_ready=1.
REQ-017 SHALL register req_we, req_addr, req_wdata and req_funct3 at acceptance; later input changes SHALL NOT affect the accepted request.
REQ-018 On acceptance SHALL go to WAIT with wait counter = WAIT_STATES-1 when WAIT_STATES>0, else directly to RESP.
REQ-019 In WAIT SHALL decrement the counter each cycle and go to RESP on the cycle after the counter reaches 0; total acceptance-to-rsp_valid latency = WAIT_STATES+1 cycles.
REQ-020 SHALL perform the storage access (write commit or read capture) on the edge entering RESP, exactly once per request.
REQ-021 In RESP SHALL assert rsp_valid and hold rsp_rdata/rsp_err stable until rsp_ready=1; then return to IDLE on that edge.
REQ-022 SHALL not accept a new request in the cycle rsp_ready completes a response; the next acceptance is at the earliest one cycle later.
REQ-023 Stores SHALL update only addressed bytes: SB byte lane addr[1:0]; SH lanes {addr[1],0} and {addr[1],1}; SW all four; little-endian.
REQ-024 Loads SHALL return LB/LH sign-extended, LBU/LHU zero-extended, LW unmodified, selected by captured addr[1:0].
REQ-025 SHALL flag rsp_err=1 with no storage write and rsp_rdata=0 when: halfword with addr[0]=1; word with addr[1:0]!=00; addr[31:2] >= DEPTH_WORDS; funct3 in {011,110,111}; or req_we=1 with funct3 100/101.
REQ-026 A load from an address stored to by the immediately preceding request SHALL return the newly written data.

Reset
REQ-027 On reset=0 SHALL asynchronously force state IDLE, counter 0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-028 Reset asserted in WAIT SHALL abandon the request with no storage write; reset asserted in RESP SHALL drop the response (write already committed remains).
REQ-029 Storage contents SHALL NOT be cleared by reset; simulation initial contents SHALL be zero.

Verification
REQ-030 SW addr 0x10 data 0xDEADBEEF then LW 0x10, WAIT_STATES=1 -> rsp_valid 2 cycles after each acceptance, LW rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-031 After REQ-030: SB addr 0x11 data 0x80, then LB 0x11 -> 0xFFFFFF80; LBU 0x11 -> 0x00000080; LW 0x10 -> 0xDEAD80EF.
REQ-032 LH addr 0x13 and SW addr 0x12 -> rsp_err=1, rsp_rdata=0, subsequent LW 0x10 unchanged.
REQ-033 LW addr 4*DEPTH_WORDS -> rsp_err=1; SW with funct3=100 -> rsp_err=1, no write.
REQ-034 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata stay stable, req_ready=0; handshake then completes and IDLE is re-entered.
REQ-035 SW issued, reset pulsed low during WAIT (WAIT_STATES=3) -> outputs return to reset values immediately, later LW of that address returns prior contents.
